// File: rtl/aco_frame_buffer_pkg.sv
// Shared ACO vector geometry and frame-buffer defaults, reused by the featurizer,
// the WRD front end and the frame buffer between them.
package aco_frame_buffer_pkg;
  localparam int FEATURE_BW     = 8;
  localparam int NUM_FEATURES   = 13;
  localparam int ACO_VECTOR_BW  = FEATURE_BW * NUM_FEATURES;
  localparam int FB_DEPTH       = 64;
  localparam int FB_DROP_CNT_BW = 8;

  typedef struct packed {
    logic                     last;
    logic [ACO_VECTOR_BW-1:0] data;
  } aco_beat_t;
endpackage

// File: rtl/aco_frame_buffer_mem.sv
// Register-array simple dual-port memory: one synchronous write port and one
// combinational read port.
module frame_fifo_mem #(
  parameter int W       = 105,
  parameter int DEPTH   = 64,
  parameter int ADDR_BW = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_BW-1:0] waddr_i,
  input  logic [W-1:0]       wdata_i,
  input  logic [ADDR_BW-1:0] raddr_i,
  output logic [W-1:0]       rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/aco_frame_buffer.sv
// Frame-atomic FIFO between the ACO featurizer and WRD: beats become visible only
// once their frame's last beat is stored; an overflowing frame is discarded whole.
module aco_frame_buffer
  import aco_frame_buffer_pkg::*;
#(
  parameter int DATA_BW     = ACO_VECTOR_BW,
  parameter int DEPTH       = FB_DEPTH,
  parameter int ADDR_BW     = $clog2(DEPTH),
  parameter int DROP_CNT_BW = FB_DROP_CNT_BW
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic [DATA_BW-1:0]     data_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic [DATA_BW-1:0]     data_o,
  output logic                   valid_o,
  output logic                   last_o,
  input  logic                   ready_i,
  input  logic                   clr_i,
  output logic                   overflow_o,
  output logic [DROP_CNT_BW-1:0] drop_count_o
);
  localparam int PTR_W = ADDR_BW + 1;
  localparam logic [PTR_W-1:0]       PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0]       DEPTH_P = PTR_W'(DEPTH);
  localparam logic [DROP_CNT_BW-1:0] CNT_ONE = DROP_CNT_BW'(1);

  logic [PTR_W-1:0]       wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  logic                   drop_q, drop_d, ovf_q, ovf_d;
  logic [DROP_CNT_BW-1:0] cnt_q, cnt_d;
  logic                   full, beat, push, ovf_evt, pop;
  logic [DATA_BW:0]       rdata;

  // Occupancy includes the uncommitted tail; a same-cycle pop does not free a slot.
  assign full    = (wr_q - rd_q) == DEPTH_P;
  assign beat    = en_i & valid_i & ~drop_q;
  assign push    = beat & ~full;
  assign ovf_evt = beat & full;
  assign valid_o = rd_q != cm_q;
  assign pop     = valid_o & ready_i;

  frame_fifo_mem #(.W(DATA_BW + 1), .DEPTH(DEPTH), .ADDR_BW(ADDR_BW)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_q[ADDR_BW-1:0]),
    .wdata_i ({last_i, data_i}),
    .raddr_i (rd_q[ADDR_BW-1:0]),
    .rdata_o (rdata)
  );

  assign data_o = valid_o ? rdata[DATA_BW-1:0] : '0;
  assign last_o = valid_o & rdata[DATA_BW];

  always_comb begin
    wr_d   = wr_q;
    cm_d   = cm_q;
    drop_d = drop_q;
    rd_d   = pop ? rd_q + PTR_ONE : rd_q;
    ovf_d  = clr_i ? 1'b0 : ovf_q;
    cnt_d  = clr_i ? '0 : cnt_q;
    if (!en_i) begin
      wr_d   = cm_q;
      drop_d = 1'b0;
    end else if (valid_i && drop_q) begin
      if (last_i) drop_d = 1'b0;
    end else if (push) begin
      wr_d = wr_q + PTR_ONE;
      if (last_i) cm_d = wr_q + PTR_ONE;
    end else if (ovf_evt) begin
      // Roll back to the last frame boundary; keep discarding until this frame ends.
      wr_d   = cm_q;
      drop_d = ~last_i;
      ovf_d  = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q   <= '0;
      cm_q   <= '0;
      rd_q   <= '0;
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign overflow_o   = ovf_q;
  assign drop_count_o = cnt_q;
endmodule

// File: tb/tb_aco_frame_buffer.sv
// Scoreboard bench for aco_frame_buffer: a frame-level queue model predicts committed
// beats and status; a negedge monitor consumes the expected beats as WRD pops them.
module tb_aco_frame_buffer;
  import aco_frame_buffer_pkg::*;
  localparam int DW = ACO_VECTOR_BW;
  localparam int BW = DW + 1;
  localparam int DEPTH = 8;
  localparam int CW = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, valid = 1'b0, last = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] data_o;
  logic valid_o, last_o, overflow_o;
  logic [CW-1:0] cnt_o;

  always #5 clk = ~clk;

  aco_frame_buffer #(.DATA_BW(DW), .DEPTH(DEPTH), .DROP_CNT_BW(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(data), .valid_i(valid),
    .last_i(last), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
    .ready_i(ready), .clr_i(clr), .overflow_o(overflow_o), .drop_count_o(cnt_o)
  );

  int errors = 0, checks = 0, pops = 0;
  bit mon_on = 1'b0;
  // Reference model: committed-but-unread beat count, pending partial frame, status.
  logic [DW:0] sb[$];
  logic [DW:0] m_part[$];
  int m_avail = 0, m_cnt = 0;
  bit m_drop = 1'b0, m_ovf = 1'b0;

  task automatic chk(string nm, logic [DW:0] act, logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete(); m_part.delete();
    m_avail = 0; m_cnt = 0; m_drop = 1'b0; m_ovf = 1'b0;
  endtask

  // Applies the rules to the inputs that were held across the edge just passed.
  task automatic model_step();
    bit full, pop;
    if (!rst_n) begin model_reset(); return; end
    full = (m_avail + m_part.size()) >= DEPTH;
    pop  = (m_avail > 0) && ready;
    if (clr) begin m_ovf = 1'b0; m_cnt = 0; end
    if (!en) begin
      m_part.delete(); m_drop = 1'b0;
    end else if (valid && m_drop) begin
      if (last) m_drop = 1'b0;
    end else if (valid && !full) begin
      m_part.push_back({last, data});
      if (last) begin
        foreach (m_part[i]) sb.push_back(m_part[i]);
        m_avail += m_part.size();
        m_part.delete();
      end
    end else if (valid) begin
      m_part.delete();
      m_drop = !last;
      m_ovf = 1'b1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    if (pop) m_avail--;
  endtask

  task automatic tick(bit e, bit v, bit l, logic [DW-1:0] d, bit r, bit c);
    @(posedge clk); #1;
    model_step();
    en = e; valid = v; last = l; data = d; ready = r; clr = c;
  endtask

  task automatic frame(int n, int base, bit r);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, i == n - 1, DW'(base + i), r, 1'b0);
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, '0, r, 1'b0);
  endtask

  task automatic clear_status();
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic basic_frame(string tag);
    int p0;
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, i == 3, DW'(i + 1), 1'b1, 1'b0);
      @(negedge clk);
      chk({tag, "_no_early_valid"}, BW'(valid_o), BW'(0));
    end
    idle(1, 1'b1);
    @(negedge clk);
    chk({tag, "_first_beat"}, {last_o, data_o}, BW'(1));
    idle(5, 1'b1);
    chk({tag, "_pops"}, BW'(pops - p0), BW'(4));
    chk({tag, "_overflow"}, BW'(overflow_o), BW'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      chk("valid_o", BW'(valid_o), BW'(m_avail > 0));
      chk("overflow_o", BW'(overflow_o), BW'(m_ovf));
      chk("drop_count_o", BW'(cnt_o), BW'(m_cnt));
      if (valid_o && ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {last_o, data_o});
        end else begin
          chk("beat", {last_o, data_o}, sb.pop_front());
        end
      end else if (!valid_o) begin
        chk("idle_outputs_zero", {last_o, data_o}, BW'(0));
      end
    end
  end

  initial begin
    int p0;
    #12;
    chk("reset_valid", BW'(valid_o), BW'(0));
    chk("reset_data", {last_o, data_o}, BW'(0));
    chk("reset_overflow", BW'(overflow_o), BW'(0));
    chk("reset_count", BW'(cnt_o), BW'(0));
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    mon_on = 1'b1;

    basic_frame("s1");

    // Full 8-beat frame blocks the following 3-beat frame.
    clear_status();
    frame(8, 16, 1'b0); frame(3, 32, 1'b0); idle(1, 1'b0);
    @(negedge clk);
    chk("s2_overflow", BW'(overflow_o), BW'(1));
    chk("s2_count", BW'(cnt_o), BW'(1));
    p0 = pops; idle(12, 1'b1);
    chk("s2_pops", BW'(pops - p0), BW'(8));

    // Overflow partway through the second frame.
    clear_status();
    frame(6, 48, 1'b0); frame(4, 64, 1'b0); idle(1, 1'b0);
    @(negedge clk);
    chk("s3_count", BW'(cnt_o), BW'(1));
    p0 = pops; idle(10, 1'b1);
    chk("s3_pops", BW'(pops - p0), BW'(6));
    p0 = pops; frame(4, 80, 1'b1); idle(8, 1'b1);
    chk("s3_after_pops", BW'(pops - p0), BW'(4));

    // Frame longer than DEPTH.
    clear_status();
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 1'b1, i == 8, DW'(96 + i), 1'b1, 1'b0);
      @(negedge clk);
      chk("s4_never_valid", BW'(valid_o), BW'(0));
    end
    idle(1, 1'b1);
    @(negedge clk);
    chk("s4_never_valid_end", BW'(valid_o), BW'(0));
    chk("s4_count", BW'(cnt_o), BW'(1));
    frame(8, 112, 1'b0); idle(1, 1'b0);
    @(negedge clk);
    chk("s4_empty_after", BW'(cnt_o), BW'(1));
    p0 = pops; idle(10, 1'b1);
    chk("s4_pops", BW'(pops - p0), BW'(8));

    // en_i drop mid-frame.
    clear_status();
    p0 = pops;
    tick(1'b1, 1'b1, 1'b0, DW'(130), 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, DW'(131), 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, DW'(132), 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, DW'(133), 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, DW'(134), 1'b1, 1'b0);
    frame(3, 140, 1'b1); idle(6, 1'b1);
    chk("s5_pops", BW'(pops - p0), BW'(3));
    chk("s5_count", BW'(cnt_o), BW'(0));

    // clr_i colliding with an overflow event.
    clear_status();
    frame(8, 150, 1'b0);
    tick(1'b1, 1'b1, 1'b1, DW'(170), 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, DW'(171), 1'b0, 1'b1);
    idle(1, 1'b0);
    @(negedge clk);
    chk("s6_clr_vs_event_ovf", BW'(overflow_o), BW'(1));
    chk("s6_clr_vs_event_cnt", BW'(cnt_o), BW'(1));
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1); idle(1, 1'b0);
    @(negedge clk);
    chk("s6_clr_ovf", BW'(overflow_o), BW'(0));
    chk("s6_clr_cnt", BW'(cnt_o), BW'(0));
    idle(10, 1'b1);

    // Saturation, then reset mid-drain.
    clear_status();
    frame(8, 180, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, DW'(200 + i), 1'b0, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    chk("s7_saturated", BW'(cnt_o), BW'(3));
    idle(2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("s8_async_valid", BW'(valid_o), BW'(0));
    chk("s8_async_data", {last_o, data_o}, BW'(0));
    chk("s8_async_ovf", BW'(overflow_o), BW'(0));
    model_reset();
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    basic_frame("s8");

    // Randomized traffic against the model.
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0)
          tick(1'b1, 1'b0, 1'b0, '0, $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
        tick($urandom_range(0, 29) != 0, 1'b1, i == len - 1,
             DW'({$urandom, $urandom, $urandom, $urandom}),
             $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
      end
    end
    idle(30, 1'b1);
    chk("final_drained", BW'(sb.size()), BW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
